mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory/peripheral port among CHANNELS requesters.
- Drives the `sel` input of a `multiplexer` instance that steers the winning requester's address/data onto the shared port.
- Sequences the port handshake: `mem_valid` out, `mem_ready` in, with a watchdog that aborts stalled transfers.
- Sits between the core/AES-accelerator masters and the data-memory interface.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among CHANNELS requesters.
// Drives the port mux select, sequences mem_valid/mem_ready and aborts stalled transfers.
module mem_port_arbiter #(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  output logic [$clog2(CHANNELS)-1:0] sel,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [CHANNELS-1:0]         ack,
  output logic [CHANNELS-1:0]         err,
  output logic                        busy
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RELEASE
  } state_t;

  state_t              state_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic [SEL_W-1:0]    ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                mem_valid_reg;
  logic                busy_reg;
  logic [CHANNELS-1:0] ack_reg;
  logic [CHANNELS-1:0] err_reg;

  logic [SEL_W-1:0]    cand_idx [CHANNELS];
  logic [CHANNELS-1:0] cand_hit;
  logic [CHANNELS-1:0] sel_onehot;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W-1:0]    ptr_next;

  // Candidate gi is the channel gi positions after ptr, wrapping past CHANNELS-1.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
      logic [SEL_W:0] sum;
      assign sum            = {1'b0, ptr_reg} + (SEL_W + 1)'(gi);
      assign cand_idx[gi]   = (sum >= (SEL_W + 1)'(CHANNELS))
                              ? SEL_W'(sum - (SEL_W + 1)'(CHANNELS))
                              : SEL_W'(sum);
      assign cand_hit[gi]   = req[cand_idx[gi]];
      assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Lowest rotated offset wins, i.e. the first requester at or after ptr.
  always_comb begin
    grant_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx = cand_idx[k];
      end
    end
  end

  assign ptr_next = (sel_reg == LAST_IDX) ? '0 : sel_reg + SEL_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      mem_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      ack_reg       <= '0;
      err_reg       <= '0;
    end else begin
      ack_reg <= '0;
      err_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            sel_reg       <= grant_idx;
            mem_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A completion on the last allowed cycle still counts as success.
          if (mem_ready) begin
            ack_reg       <= sel_onehot;
            mem_valid_reg <= 1'b0;
            ptr_reg       <= ptr_next;
            state_reg     <= ST_RELEASE;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg       <= sel_onehot;
            mem_valid_reg <= 1'b0;
            ptr_reg       <= ptr_next;
            state_reg     <= ST_RELEASE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          mem_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_reg;
  assign mem_valid = mem_valid_reg;
  assign busy      = busy_reg;
  assign ack       = ack_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed vector table, corner-case sequences,
// and randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int CH = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] req = '0;
  logic          mem_ready = 1'b0;
  logic [1:0]    sel;
  logic          mem_valid;
  logic [CH-1:0] ack;
  logic [CH-1:0] err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.CHANNELS(CH), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;
  } vec_t;

  vec_t tbl [12];

  // Model state: owner of the port (-1 when none), active cycles spent,
  // whether we are in the one-cycle handback, and the rotation pointer.
  int         m_owner;
  int         m_age;
  bit         m_rel;
  int         m_ptr;
  int         m_sel;
  logic [3:0] m_ack;
  logic [3:0] m_err;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {20'd0, sel, mem_valid, ack, err, busy};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    mem_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age = 0;
    m_rel = 1'b0;
    m_ptr = 0;
    m_sel = 0;
    m_ack = '0;
    m_err = '0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rdy);
    logic [3:0] nack;
    logic [3:0] nerr;
    bit done;
    nack = '0;
    nerr = '0;
    done = 1'b0;
    if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_owner >= 0) begin
      m_age++;
      if (rdy) begin
        nack[m_owner] = 1'b1;
        done = 1'b1;
      end else if (m_age == TO) begin
        nerr[m_owner] = 1'b1;
        done = 1'b1;
      end
      if (done) begin
        m_ptr = (m_owner + 1) % CH;
        m_owner = -1;
        m_rel = 1'b1;
      end
    end else if (r != 0) begin
      for (int k = 0; k < CH; k++) begin
        int i;
        i = (m_ptr + k) % CH;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
        end
      end
      m_sel = m_owner;
      m_age = 0;
    end
    m_ack = nack;
    m_err = nerr;
  endtask

  initial begin
    // req, ready -> sel, valid, ack, err, busy observed after the edge
    tbl[0]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0100, 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0011, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0011, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0011, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0011, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0001, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{4'b0001, 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_sel", 0, 32'(sel), 32'd0);
    check("rst_valid", 0, 32'(mem_valid), 32'd0);
    check("rst_ack", 0, 32'(ack), 32'd0);
    check("rst_err", 0, 32'(err), 32'd0);
    check("rst_busy", 0, 32'(busy), 32'd0);
    reset = 1'b0;

    // Vector table: single grant, wrap-around search, dropped request
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      mem_ready = tbl[i].ready;
      step();
      check("vec", i, obs(),
            {20'd0, tbl[i].sel, tbl[i].valid, tbl[i].ack, tbl[i].err, tbl[i].busy});
    end

    // All channels requesting, ready every active cycle: acks 3 cycles apart, order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    mem_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] exp_ack;
      step();
      exp_ack = (k % 3 == 2) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      check("rr_ack", k, 32'(ack), 32'(exp_ack));
      if (ack != 0) $display("txn rr cycle=%0d ack=%b sel=%0d", k, ack, sel);
    end

    // Timeout: valid for exactly TO cycles, then one err pulse, then rotation
    do_reset();
    req = 4'b0010;
    mem_ready = 1'b0;
    begin
      int vcount;
      int ecount;
      int acount;
      vcount = 0;
      ecount = 0;
      acount = 0;
      for (int k = 1; k <= TO + 1; k++) begin
        step();
        if (mem_valid) vcount++;
        if (err != 0) ecount++;
        if (ack != 0) acount++;
      end
      check("to_valid_cycles", 0, 32'(vcount), 32'(TO));
      check("to_err", 0, 32'(err), 32'(4'b0010));
      check("to_err_count", 0, 32'(ecount), 32'd1);
      check("to_ack_count", 0, 32'(acount), 32'd0);
      $display("txn timeout err=%b", err);
      req = 4'b0011;
      step();
      check("to_idle_busy", 0, 32'(busy), 32'd0);
      step();
      check("to_rotate_sel", 0, 32'(sel), 32'd0);
    end

    // Ready first high on the last allowed active cycle: ack wins over err
    do_reset();
    req = 4'b0001;
    mem_ready = 1'b0;
    for (int k = 1; k <= TO; k++) step();
    check("late_valid", 0, 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    step();
    check("late_ack", 0, 32'(ack), 32'(4'b0001));
    check("late_err", 0, 32'(err), 32'd0);
    $display("txn late ack=%b err=%b", ack, err);
    mem_ready = 1'b0;

    // Reset mid-ACTIVE with sel=2: immediate clear, no later ack/err
    do_reset();
    req = 4'b0100;
    step();
    step();
    check("mid_setup_sel", 0, 32'(sel), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_valid", 0, 32'(mem_valid), 32'd0);
    check("mid_busy", 0, 32'(busy), 32'd0);
    check("mid_sel", 0, 32'(sel), 32'd0);
    step();
    reset = 1'b0;
    req = '0;
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_no_resp", k, 32'({ack, err}), 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 9) < 2);
      model_edge(req, mem_ready);
      step();
      check("rand", cyc, obs(),
            {20'd0, 2'(m_sel), (m_owner >= 0), m_ack, m_err, (m_owner >= 0) || m_rel});
      if (ack != 0 || err != 0)
        $display("txn rand cycle=%0d sel=%0d ack=%b err=%b", cyc, sel, ack, err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
